dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port (we/addr/wdata in, asynchronous rdata out) between two requesters:
  - the CPU load/store port;
  - an external loader/debug port that moves word bursts.
- Sits between `riscv_cpu`, the external loader and `data_mem` in the top level.
- Scheduling: CPU has default priority, the external port has burst locking, and an aging counter guarantees external progress.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits.
- LEN_W, 4, burst length field width; a burst is ext_len+1 beats, 1..2^LEN_W.
- MAX_WAIT, 8, cycles an external request may be refused before it gets priority.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-low reset.
- cpu_req, input, 1, CPU access request for one beat.
- cpu_we, input, 1, CPU write (1) / read (0).
- cpu_addr, input, ADDR_W, CPU byte address.
- cpu_wdata, input, DATA_W, CPU write data.
- cpu_gnt, output, 1, CPU beat accepted this cycle.
- cpu_rdata, output, DATA_W, registered CPU read data.
- cpu_rvalid, output, 1, cpu_rdata valid (one-cycle pulse).
- ext_req, input, 1, external burst request.
- ext_we, input, 1, burst direction; sampled at burst start.
- ext_addr, input, ADDR_W, burst base byte address; sampled at burst start.
- ext_len, input, LEN_W, beats minus one; sampled at burst start.
- ext_wdata, input, DATA_W, write data for the current beat.
- ext_gnt, output, 1, external beat accepted this cycle.
- ext_rdata, output, DATA_W, registered external read data.
- ext_rvalid, output, 1, ext_rdata valid (one-cycle pulse).
- ext_done, output, 1, pulse with the last beat of a burst.
- mem_we, output, 1, to data_mem write enable.
- mem_addr, output, ADDR_W, to data_mem address.
- mem_wdata, output, DATA_W, to data_mem write data.
- mem_rdata, input, DATA_W, from data_mem (combinational read).

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, wait_cnt=0, beat_cnt=0;
  - cpu_rvalid=ext_rvalid=ext_done=0, cpu_rdata=ext_rdata=0;
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset mid-burst abandons the burst; no further mem_we is issued.
- FSM states:
  - IDLE/CPU: no burst owns the port.
  - EXT: external burst locked.
- Arbitration in IDLE/CPU, each cycle:
  - If wait_cnt==MAX_WAIT and ext_req: start the burst this cycle. ext_gnt=1, cpu_gnt=0.
  - Else if cpu_req: cpu_gnt=1.
  - Else if ext_req: start the burst. ext_gnt=1.
  - Else idle: mem_we=0, mem_addr held at last value.
- Starting a burst:
  - latches base=ext_addr, len=ext_len, dir=ext_we;
  - beat_cnt=0; issues beat 0 in the same cycle;
  - goes to EXT if len>0, else stays in IDLE with ext_done=1.
- In EXT:
  - ext_gnt=1 every cycle; cpu_gnt=0 regardless of cpu_req (burst is not preemptible).
  - Beat k: mem_addr = base + 4*k, wrapping modulo 2^ADDR_W. mem_we=dir. mem_wdata=ext_wdata for that cycle.
  - Last beat (k==len): ext_done=1, return to IDLE. The CPU may be granted the next cycle.
  - ext_req is ignored while in EXT.
- Combinational mem drive:
  - mem_we/mem_addr/mem_wdata select the granted requester's beat in the same cycle (zero-latency grant).
  - mem_we=0 whenever no grant is issued.
- Read return:
  - mem_rdata is registered at the clk edge ending the beat.
  - cpu_rvalid/ext_rvalid pulse the following cycle, read beats only. Latency is 1 cycle from grant.
  - Writes produce no rvalid.
- Aging counter wait_cnt:
  - increments, saturating at MAX_WAIT, on each cycle ext_req=1 and ext_gnt=0;
  - clears on any burst start.
- Simultaneous cpu_req and ext_req with wait_cnt<MAX_WAIT: the CPU wins.
- A new burst may start in the cycle after ext_done.

Decomposition:
- Shared package `dmem_arb_pkg`:
  - state enum {ST_IDLE, ST_EXT};
  - WORD_BYTES=4 constant.
  - Parameter defaults stay on the module.
- One natural sub-module, `arb_age_counter`: the saturating wait counter with `sat` flag output.

Test Plan:
- Reset mid-burst: reset=0 during beat 2 of a len=7 write burst -> next cycle mem_we=0, state IDLE; no further writes; all outputs 0.
- CPU only: cpu_req with read of 0x10, where mem holds 0x1234 -> cpu_gnt same cycle, mem_addr=0x10; next cycle cpu_rvalid=1, cpu_rdata=0x1234.
- Simultaneous requests: cpu_req and ext_req on the same cycle, wait_cnt=0 -> cpu_gnt=1, ext_gnt=0, wait_cnt becomes 1.
- Aging: cpu_req held continuously, ext_req held -> after 8 refused cycles, the 9th cycle gives ext_gnt=1 and cpu_gnt=0; wait_cnt clears.
- Write burst: ext_addr=0x100, len=3, write 0xA..0xD -> mem_addr 0x100/104/108/10C on 4 consecutive cycles; ext_done on the 4th; cpu_req held throughout sees cpu_gnt=0 until the cycle after.
- Wrap and single beat: base=0xFFFFFFF8, len=2 read -> addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x0; a len=0 burst -> one beat with ext_done the same cycle.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory port arbiter
//
// Purpose: arbiter FSM state encoding and the word size used for burst address
// stepping. Parameter defaults live on the modules, not here.
package dmem_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,  // no burst owns the port; CPU or a new burst may be granted
    ST_EXT  = 1'b1   // external burst locked onto the port
  } arb_state_e;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/arb_age_counter.sv
// rtl/arb_age_counter.sv - saturating wait counter for external-port aging
//
// Purpose: counts cycles an external request has been refused and flags when
// the count reaches MAX_WAIT, at which point the external port takes priority.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-low reset, clears the count
//   inc_i  - external request refused this cycle
//   clr_i  - a burst starts this cycle
//   sat_o  - count has reached MAX_WAIT
module arb_age_counter #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_o = (cnt_q == MAX_V);

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares one data-memory port between CPU and an external burst port
//
// Purpose: zero-latency grant of the single data_mem port. CPU wins by default,
// an external burst locks the port until its last beat, and an aging counter
// forces an external burst start after MAX_WAIT refused cycles.
// Ports:
//   clk, reset                          - clock, synchronous active-low reset
//   cpu_req/we/addr/wdata -> cpu_gnt    - single-beat CPU access, granted same cycle
//   cpu_rdata, cpu_rvalid               - registered read return, one cycle after grant
//   ext_req/we/addr/len/wdata -> ext_gnt- external burst of ext_len+1 word beats
//   ext_rdata, ext_rvalid, ext_done     - registered read return, last-beat pulse
//   mem_we, mem_addr, mem_wdata         - combinational drive to data_mem
//   mem_rdata                           - combinational read data from data_mem
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [LEN_W-1:0]  ext_len,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_rvalid,
  output logic              ext_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q, state_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              dir_q, dir_d;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
  logic [DATA_W-1:0] cpu_rdata_q, ext_rdata_q;
  logic              cpu_rvalid_q, ext_rvalid_q;

  logic              age_sat;
  logic              ext_start;
  logic              cpu_gnt_c, ext_gnt_c;
  logic              beat_we;
  logic [ADDR_W-1:0] beat_addr;
  logic [DATA_W-1:0] beat_wdata;
  logic              last_beat;

  arb_age_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_age (
    .clk   (clk),
    .reset (reset),
    .inc_i (ext_req && !ext_gnt_c),
    .clr_i (ext_start),
    .sat_o (age_sat)
  );

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    len_d      = len_q;
    base_d     = base_q;
    dir_d      = dir_q;
    ext_start  = 1'b0;
    cpu_gnt_c  = 1'b0;
    ext_gnt_c  = 1'b0;
    beat_we    = 1'b0;
    // With no grant the address bus keeps its last value to avoid toggling.
    beat_addr  = addr_hold_q;
    beat_wdata = '0;
    last_beat  = 1'b0;

    case (state_q)
      ST_EXT: begin
        // Locked burst: ext_req and cpu_req are both ignored until the last beat.
        ext_gnt_c  = 1'b1;
        beat_we    = dir_q;
        beat_addr  = base_q + (ADDR_W'(beat_q) * ADDR_W'(WORD_BYTES));
        beat_wdata = ext_wdata;
        last_beat  = (beat_q == len_q);
        if (last_beat) begin
          state_d = ST_IDLE;
          beat_d  = '0;
        end else begin
          beat_d  = beat_q + LEN_W'(1);
        end
      end

      default: begin
        if (ext_req && (age_sat || !cpu_req)) begin
          // Burst start issues beat 0 immediately from the live request fields.
          ext_start  = 1'b1;
          ext_gnt_c  = 1'b1;
          beat_we    = ext_we;
          beat_addr  = ext_addr;
          beat_wdata = ext_wdata;
          base_d     = ext_addr;
          len_d      = ext_len;
          dir_d      = ext_we;
          last_beat  = (ext_len == '0);
          if (last_beat) begin
            beat_d = '0;
          end else begin
            state_d = ST_EXT;
            beat_d  = LEN_W'(1);
          end
        end else if (cpu_req) begin
          cpu_gnt_c  = 1'b1;
          beat_we    = cpu_we;
          beat_addr  = cpu_addr;
          beat_wdata = cpu_wdata;
        end
      end
    endcase

    addr_hold_d = beat_addr;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      len_q        <= '0;
      base_q       <= '0;
      dir_q        <= 1'b0;
      addr_hold_q  <= '0;
      cpu_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
      ext_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      len_q        <= len_d;
      base_q       <= base_d;
      dir_q        <= dir_d;
      addr_hold_q  <= addr_hold_d;
      // Read data is captured at the edge that ends the granted read beat.
      cpu_rvalid_q <= cpu_gnt_c && !beat_we;
      ext_rvalid_q <= ext_gnt_c && !beat_we;
      if (cpu_gnt_c && !beat_we) begin
        cpu_rdata_q <= mem_rdata;
      end
      if (ext_gnt_c && !beat_we) begin
        ext_rdata_q <= mem_rdata;
      end
    end
  end

  assign cpu_gnt    = cpu_gnt_c;
  assign ext_gnt    = ext_gnt_c;
  assign ext_done   = ext_gnt_c && last_beat;
  assign mem_we     = beat_we;
  assign mem_addr   = beat_addr;
  assign mem_wdata  = beat_wdata;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign ext_rdata  = ext_rdata_q;
  assign ext_rvalid = ext_rvalid_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

  localparam int MAX_WAIT = 8;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        ext_req, ext_we;
  logic [31:0] ext_addr;
  logic [3:0]  ext_len;
  logic [31:0] ext_wdata;
  logic        ext_gnt;
  logic [31:0] ext_rdata;
  logic        ext_rvalid, ext_done;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] mem_arr [0:255];
  logic        mem_init;

  dmem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .LEN_W(4), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_len(ext_len),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rdata(ext_rdata),
    .ext_rvalid(ext_rvalid), .ext_done(ext_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(int i);
    return (i == 4) ? 32'h0000_1234 : (32'hC0DE_0000 | 32'(i));
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'((a >> 2) & 32'hFF);
  endfunction

  // Bench-side data memory: combinational read, write at the clock edge.
  assign mem_rdata = mem_arr[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= init_val(i);
    end else if (mem_we) begin
      mem_arr[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 0; ext_we = 0; ext_addr = '0; ext_len = '0; ext_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 0; mem_init = 1; idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk); mem_init = 0; reset = 1; #1;
    tests_run++;
    if ({cpu_gnt, ext_gnt, mem_we, ext_done, cpu_rvalid, ext_rvalid} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b want 000000", {cpu_gnt, ext_gnt, mem_we, ext_done, cpu_rvalid, ext_rvalid});
    end
    tests_run++;
    if ({mem_addr, mem_wdata, cpu_rdata, ext_rdata} !== 128'b0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h %h %h %h want all 0", mem_addr, mem_wdata, cpu_rdata, ext_rdata);
    end
  endtask

  task automatic test_cpu_only();
    @(negedge clk); cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; #1;
    tests_run++;
    if ({cpu_gnt, ext_gnt, mem_we} !== 3'b100 || mem_addr !== 32'h10) begin
      tests_failed++;
      $display("FAIL cpu_read_gnt: got gnt/ext/we=%b addr=%h want 100 addr=00000010", {cpu_gnt, ext_gnt, mem_we}, mem_addr);
    end
    @(negedge clk); cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'hCAFE_0020; #1;
    tests_run++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h1234) begin
      tests_failed++;
      $display("FAIL cpu_read_data: got rvalid=%b rdata=%h want 1 00001234", cpu_rvalid, cpu_rdata);
    end
    tests_run++;
    if ({cpu_gnt, mem_we} !== 2'b11 || mem_addr !== 32'h20 || mem_wdata !== 32'hCAFE_0020) begin
      tests_failed++;
      $display("FAIL cpu_write: got gnt/we=%b addr=%h wdata=%h want 11 00000020 cafe0020", {cpu_gnt, mem_we}, mem_addr, mem_wdata);
    end
    @(negedge clk); idle_inputs(); #1;
    tests_run++;
    if (cpu_rvalid !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h20) begin
      tests_failed++;
      $display("FAIL cpu_write_norvalid: got rvalid=%b we=%b addr=%h want 0 0 00000020", cpu_rvalid, mem_we, mem_addr);
    end
    @(negedge clk); cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20; #1;
    @(negedge clk); idle_inputs(); #1;
    tests_run++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hCAFE_0020) begin
      tests_failed++;
      $display("FAIL cpu_readback: got rvalid=%b rdata=%h want 1 cafe0020", cpu_rvalid, cpu_rdata);
    end
  endtask

  // Cycle 1 is the simultaneous-request case; cycles 1..8 refuse ext, cycle 9 ages it in.
  task automatic test_aging();
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
      ext_req = 1; ext_we = 0; ext_addr = 32'h40; ext_len = 4'd0;
      #1;
      if (c == 9) begin
        tests_run++;
        if ({cpu_gnt, ext_gnt, ext_done, mem_we} !== 4'b0110 || mem_addr !== 32'h40) begin
          tests_failed++;
          $display("FAIL aging_grant: got cpu/ext/done/we=%b addr=%h want 0110 00000040", {cpu_gnt, ext_gnt, ext_done, mem_we}, mem_addr);
        end
      end else begin
        tests_run++;
        if ({cpu_gnt, ext_gnt} !== 2'b10) begin
          tests_failed++;
          $display("FAIL aging_cpu_wins_c%0d: got cpu/ext=%b want 10", c, {cpu_gnt, ext_gnt});
        end
      end
      if (c == 10) begin
        tests_run++;
        if ({ext_rvalid, cpu_rvalid} !== 2'b10 || ext_rdata !== 32'hC0DE_0010) begin
          tests_failed++;
          $display("FAIL aging_ext_read: got ext/cpu rvalid=%b rdata=%h want 10 c0de0010", {ext_rvalid, cpu_rvalid}, ext_rdata);
        end
      end
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_write_burst();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        cpu_req = 0;
        ext_req = 1; ext_we = 1; ext_addr = 32'h100; ext_len = 4'd3;
      end else begin
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h104;
        ext_req = 0; ext_we = 0; ext_addr = 32'hDEAD_0000; ext_len = 4'd0;
      end
      ext_wdata = 32'hA + 32'(k);
      #1;
      tests_run++;
      if ({cpu_gnt, ext_gnt, mem_we, ext_done} !== {3'b011, k == 3} ||
          mem_addr !== 32'h100 + 32'(4 * k) || mem_wdata !== 32'hA + 32'(k)) begin
        tests_failed++;
        $display("FAIL wburst_beat%0d: got cpu/ext/we/done=%b addr=%h wdata=%h want %b %h %h", k,
                 {cpu_gnt, ext_gnt, mem_we, ext_done}, mem_addr, mem_wdata, {3'b011, k == 3},
                 32'h100 + 32'(4 * k), 32'hA + 32'(k));
      end
    end
    @(negedge clk); ext_req = 0; ext_wdata = '0; #1;
    tests_run++;
    if ({cpu_gnt, ext_gnt, ext_rvalid} !== 3'b100 || mem_addr !== 32'h104) begin
      tests_failed++;
      $display("FAIL wburst_cpu_after: got cpu/ext/ervalid=%b addr=%h want 100 00000104", {cpu_gnt, ext_gnt, ext_rvalid}, mem_addr);
    end
    @(negedge clk); idle_inputs(); #1;
    tests_run++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hB) begin
      tests_failed++;
      $display("FAIL wburst_readback: got rvalid=%b rdata=%h want 1 0000000b", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_wrap_single();
    logic [31:0] a;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        ext_req = 1; ext_we = 0; ext_addr = 32'hFFFF_FFF8; ext_len = 4'd2;
      end else begin
        ext_req = $urandom_range(0, 1) == 1; ext_we = 1; ext_addr = $urandom; ext_len = 4'd5;
      end
      #1;
      a = 32'hFFFF_FFF8 + 32'(4 * k);
      tests_run++;
      if ({ext_gnt, mem_we, ext_done} !== {2'b10, k == 2} || mem_addr !== a) begin
        tests_failed++;
        $display("FAIL wrap_beat%0d: got gnt/we/done=%b addr=%h want %b %h", k, {ext_gnt, mem_we, ext_done}, mem_addr, {2'b10, k == 2}, a);
      end
      if (k > 0) begin
        a = 32'hFFFF_FFF8 + 32'(4 * (k - 1));
        tests_run++;
        if (ext_rvalid !== 1'b1 || ext_rdata !== init_val(widx(a))) begin
          tests_failed++;
          $display("FAIL wrap_rdata%0d: got rvalid=%b rdata=%h want 1 %h", k, ext_rvalid, ext_rdata, init_val(widx(a)));
        end
      end
    end
    // Single-beat burst right after ext_done, then another back-to-back.
    @(negedge clk); ext_req = 1; ext_we = 0; ext_addr = 32'h10; ext_len = 4'd0; #1;
    tests_run++;
    if ({ext_gnt, ext_done, mem_we} !== 3'b110 || mem_addr !== 32'h10 || ext_rvalid !== 1'b1 || ext_rdata !== 32'hC0DE_0000) begin
      tests_failed++;
      $display("FAIL single_read: got gnt/done/we=%b addr=%h rvalid=%b rdata=%h want 110 00000010 1 c0de0000",
               {ext_gnt, ext_done, mem_we}, mem_addr, ext_rvalid, ext_rdata);
    end
    @(negedge clk); ext_we = 1; ext_addr = 32'h24; ext_wdata = 32'h77; #1;
    tests_run++;
    if ({ext_gnt, ext_done, mem_we} !== 3'b111 || mem_addr !== 32'h24 || ext_rvalid !== 1'b1 || ext_rdata !== 32'h1234) begin
      tests_failed++;
      $display("FAIL single_write: got gnt/done/we=%b addr=%h rvalid=%b rdata=%h want 111 00000024 1 00001234",
               {ext_gnt, ext_done, mem_we}, mem_addr, ext_rvalid, ext_rdata);
    end
    @(negedge clk); idle_inputs(); #1;
    tests_run++;
    if ({ext_rvalid, ext_done, ext_gnt} !== 3'b000) begin
      tests_failed++;
      $display("FAIL single_write_norvalid: got rvalid/done/gnt=%b want 000", {ext_rvalid, ext_done, ext_gnt});
    end
  endtask

  task automatic test_reset_mid_burst();
    int stray_writes;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ext_req = (k == 0); ext_we = 1; ext_addr = 32'h200; ext_len = 4'd7; ext_wdata = 32'h5000 + 32'(k);
      if (k == 2) reset = 0;
      #1;
      if (k < 2) begin
        tests_run++;
        if ({ext_gnt, mem_we} !== 2'b11 || mem_addr !== 32'h200 + 32'(4 * k)) begin
          tests_failed++;
          $display("FAIL rst_burst_beat%0d: got gnt/we=%b addr=%h want 11 %h", k, {ext_gnt, mem_we}, mem_addr, 32'h200 + 32'(4 * k));
        end
      end
    end
    @(negedge clk); reset = 1; idle_inputs(); #1;
    tests_run++;
    if ({cpu_gnt, ext_gnt, mem_we, ext_done, cpu_rvalid, ext_rvalid} !== 6'b0 ||
        {mem_addr, mem_wdata, cpu_rdata, ext_rdata} !== 128'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: got ctl=%b addr=%h wdata=%h crd=%h erd=%h want all 0",
               {cpu_gnt, ext_gnt, mem_we, ext_done, cpu_rvalid, ext_rvalid}, mem_addr, mem_wdata, cpu_rdata, ext_rdata);
    end
    stray_writes = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (mem_we === 1'b1 || ext_gnt === 1'b1) stray_writes++;
    end
    tests_run++;
    if (stray_writes !== 0) begin
      tests_failed++;
      $display("FAIL rst_no_more_writes: got %0d write cycles want 0", stray_writes);
    end
    for (int b = 3; b < 8; b++) begin
      tests_run++;
      if (mem_arr[widx(32'h200) + b] !== init_val(widx(32'h200) + b)) begin
        tests_failed++;
        $display("FAIL rst_mem_beat%0d: got %h want %h", b, mem_arr[widx(32'h200) + b], init_val(widx(32'h200) + b));
      end
    end
    @(negedge clk); cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; #1;
    tests_run++;
    if ({cpu_gnt, ext_gnt} !== 2'b10) begin
      tests_failed++;
      $display("FAIL rst_idle_cpu: got cpu/ext=%b want 10", {cpu_gnt, ext_gnt});
    end
  endtask

  // Reference: a burst is a queue-like count of remaining beats with a running address.
  task automatic test_random();
    logic [31:0] ref_mem [0:255];
    int          left, age;
    logic [31:0] next_a, last_a, a, d, x_crd, x_erd;
    logic        bdir, w, cg, eg, dn, x_cv, x_ev;
    @(negedge clk); idle_inputs(); #1;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_arr[i];
    left = 0; age = 0; last_a = 32'h10; next_a = '0; bdir = 0;
    x_cv = 0; x_ev = 0; x_crd = '0; x_erd = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      cpu_req = $urandom_range(0, 99) < 60; cpu_we = $urandom_range(0, 1) == 1;
      cpu_addr = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3)) : 32'($urandom_range(0, 255)) << 2;
      cpu_wdata = $urandom;
      ext_req = $urandom_range(0, 99) < 35; ext_we = $urandom_range(0, 1) == 1;
      ext_addr = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3)) : 32'($urandom_range(0, 255)) << 2;
      ext_len = 4'($urandom_range(0, 5)); ext_wdata = $urandom;
      #1;
      tests_run++;
      if (cpu_rvalid !== x_cv || ext_rvalid !== x_ev || (x_cv && cpu_rdata !== x_crd) || (x_ev && ext_rdata !== x_erd)) begin
        tests_failed++;
        $display("FAIL rand_rvalid_c%0d: got cv=%b crd=%h ev=%b erd=%h want %b %h %b %h",
                 cyc, cpu_rvalid, cpu_rdata, ext_rvalid, ext_rdata, x_cv, x_crd, x_ev, x_erd);
      end
      cg = 0; eg = 0; dn = 0; w = 0; a = last_a; d = '0;
      if (left > 0) begin
        eg = 1; a = next_a; w = bdir; d = ext_wdata;
        left--; dn = (left == 0); next_a = next_a + 4;
      end else if (ext_req && (age == MAX_WAIT || !cpu_req)) begin
        eg = 1; a = ext_addr; w = ext_we; d = ext_wdata;
        left = int'(ext_len); dn = (ext_len == 0); next_a = ext_addr + 4; bdir = ext_we; age = 0;
      end else if (cpu_req) begin
        cg = 1; a = cpu_addr; w = cpu_we; d = cpu_wdata;
      end
      if (ext_req && !eg && age < MAX_WAIT) age++;
      tests_run++;
      if ({cpu_gnt, ext_gnt, mem_we, ext_done} !== {cg, eg, w, dn} || mem_addr !== a) begin
        tests_failed++;
        $display("FAIL rand_grant_c%0d: got cpu/ext/we/done=%b addr=%h want %b %h",
                 cyc, {cpu_gnt, ext_gnt, mem_we, ext_done}, mem_addr, {cg, eg, w, dn}, a);
      end
      if (w) begin
        tests_run++;
        if (mem_wdata !== d) begin
          tests_failed++;
          $display("FAIL rand_wdata_c%0d: got %h want %h", cyc, mem_wdata, d);
        end
        ref_mem[widx(a)] = d;
      end
      x_cv = cg && !w; x_ev = eg && !w;
      if (x_cv) x_crd = ref_mem[widx(a)];
      if (x_ev) x_erd = ref_mem[widx(a)];
      last_a = a;
    end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    reset = 1; mem_init = 0; idle_inputs();
    test_reset();
    test_cpu_only();
    test_aging();
    test_write_burst();
    test_wrap_single();
    test_reset_mid_burst();
    test_random();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
